// File: rtl/afc_ncntr.sv
// VCO frequency counter for AFC calibration: counts prescaled VCO strobes
// inside the enable window and latches the count on a datasyn rising edge.
module afc_ncntr #(
  parameter int CNT_W   = 15,
  parameter int PRE_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             afc_cntr_rstn,
  input  logic             afc_cntr_en,
  input  logic             afc_cntr_datasyn,
  input  logic             vco_pulse,
  output logic [CNT_W-1:0] a2d_afc_ncntr,
  output logic             ncntr_valid,
  output logic             ncntr_sat
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    HOLD
  } state_t;

  localparam logic [3:0]       PRE_MAX = 4'(PRE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [3:0]       pre;
  logic [3:0]       pre_nxt;
  logic             sat_nxt;
  logic             active;
  logic             datasyn_d;
  logic             latch;

  assign latch = afc_cntr_rstn & afc_cntr_datasyn & ~datasyn_d;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pre_nxt   = pre;
    sat_nxt   = ncntr_sat;
    active    = 1'b0;
    unique case (state)
      IDLE: begin
        if (afc_cntr_en) begin
          state_nxt = COUNT;
          active    = 1'b1;
        end
      end
      COUNT: begin
        if (!afc_cntr_en) state_nxt = HOLD;
        else              active    = 1'b1;
      end
      HOLD: begin
        if (afc_cntr_en) state_nxt = COUNT;
      end
      default: state_nxt = IDLE;
    endcase
    if (active && vco_pulse) begin
      if (pre == PRE_MAX) begin
        pre_nxt = '0;
        if (cnt == CNT_MAX) sat_nxt = 1'b1;
        else                cnt_nxt = cnt + 1'b1;
      end else begin
        pre_nxt = pre + 4'd1;
      end
    end
    // Synchronous clear overrides everything but the async reset
    if (!afc_cntr_rstn) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      pre_nxt   = '0;
      sat_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      pre           <= '0;
      ncntr_sat     <= 1'b0;
      datasyn_d     <= 1'b0;
      ncntr_valid   <= 1'b0;
      a2d_afc_ncntr <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pre         <= pre_nxt;
      ncntr_sat   <= sat_nxt;
      datasyn_d   <= afc_cntr_datasyn;
      ncntr_valid <= latch;
      if (latch) a2d_afc_ncntr <= cnt;
    end
  end

endmodule

// File: doc/afc_ncntr.md
Name: afc_ncntr

Overview:
- Digital model and FPGA-prototype replacement of the VCO frequency counter that the AFC calibration engine drives.
- Consumes the AFC counter-control trio (afc_cntr_rstn, afc_cntr_en, afc_cntr_datasyn) and counts prescaled VCO edge strobes during the enable window.
- Returns the latched count to the AFC engine as a2d_afc_ncntr.
- Sits between the afc block and the divided-VCO edge detector, all in the AFC clk domain.

Parameters:
CNT_W, 15, width of count and a2d_afc_ncntr
PRE_DIV, 1, VCO strobes per count increment (legal 1..16)

Ports:
clk  input  1  AFC clock
rst  input  1  asynchronous reset, active-high
afc_cntr_rstn  input  1  synchronous counter clear, active-low
afc_cntr_en  input  1  count window enable
afc_cntr_datasyn  input  1  latch request; rising edge effective
vco_pulse  input  1  one-cycle strobe per divided VCO edge, already in clk domain
a2d_afc_ncntr  output  CNT_W  latched count
ncntr_valid  output  1  one-cycle pulse after each latch
ncntr_sat  output  1  count saturated since last clear

Behaviour:
Reset:
- rst high clears all state immediately: cnt=0, pre=0, datasyn_d=0, state=IDLE.
- Outputs under rst: a2d_afc_ncntr=0, ncntr_valid=0, ncntr_sat=0.
Priority (highest first): rst, afc_cntr_rstn low, datasyn edge/count logic.
afc_cntr_rstn low (sampled):
- Clears cnt, pre and ncntr_sat; forces state to IDLE; forces ncntr_valid to 0.
- a2d_afc_ncntr holds its last latched value.
- datasyn_d still tracks afc_cntr_datasyn.
FSM states: IDLE, COUNT, HOLD.
- IDLE -> COUNT when afc_cntr_rstn=1 and afc_cntr_en=1.
- COUNT -> HOLD when afc_cntr_en=0.
- HOLD -> COUNT when afc_cntr_en=1. Accumulation resumes; cnt is not cleared.
- IDLE and HOLD freeze cnt and pre.
Counting:
- Active in any cycle where afc_cntr_en=1 and state is COUNT, or state is IDLE with the transition condition true. The first enabled cycle counts.
- On vco_pulse=1: if pre==PRE_DIV-1, set pre=0 and increment cnt; otherwise pre+1.
- PRE_DIV=1 increments cnt on every pulse.
Saturation:
- cnt stops at 2^CNT_W-1 (32767 for the default CNT_W).
- ncntr_sat sets on the first increment attempt while at max and stays set until afc_cntr_rstn low or rst.
- Count never wraps.
Latch:
- datasyn_d registers afc_cntr_datasyn every cycle.
- Edge condition: afc_cntr_datasyn=1 and datasyn_d=0, in any state.
- At the clock edge where the condition is sampled, a2d_afc_ncntr takes the registered cnt from before that cycle's increment.
- A vco_pulse in the same cycle is counted in cnt but excluded from the latch.
- ncntr_valid is high for exactly the one cycle after that edge.
- A held-high datasyn produces one latch only.
- Latch in COUNT is a snapshot; counting continues.
Simultaneous events:
- afc_cntr_en falls while vco_pulse=1: the pulse is not counted, because en is sampled low.
- afc_cntr_rstn low with a datasyn edge: the clear wins and no latch occurs.
Latency: datasyn edge to new a2d_afc_ncntr is 1 clk edge; to ncntr_valid high is 1 cycle.
Reset mid-count: state discarded. After release the block waits in IDLE for afc_cntr_en.
Widths: cnt is CNT_W bits. pre is 4 bits and compares against PRE_DIV-1.

Test Plan:
- Reset: assert rst mid-operation with cnt=57 -> a2d_afc_ncntr=0, ncntr_sat=0, ncntr_valid=0 immediately, without waiting for clk.
- Basic window (PRE_DIV=1):
  - Stimulus: afc_cntr_rstn low 2 cycles, then en high for 128 cycles with vco_pulse every cycle, then en low, then datasyn 0->1.
  - Response: a2d_afc_ncntr=128 and ncntr_valid high for 1 cycle.
- Prescale (PRE_DIV=4):
  - Stimulus: vco_pulse every other cycle, en window of 400 cycles, then datasyn edge.
  - Response: a2d_afc_ncntr=50.
- Saturation and clear:
  - Stimulus: en high for 40000 cycles with a pulse every cycle.
  - Response: cnt holds 32767 and ncntr_sat=1.
  - Follow-up: datasyn edge, then afc_cntr_rstn low.
  - Response: a2d_afc_ncntr=32767 is latched, ncntr_sat=0 after the clear, and a2d_afc_ncntr still reads 32767.
- Snapshot collision:
  - Stimulus: in COUNT with cnt=20, datasyn rise coincides with vco_pulse.
  - Response: a2d_afc_ncntr=20 and internal cnt=21.
  - Follow-up: datasyn held high for 10 cycles.
  - Response: exactly one ncntr_valid pulse.
- Resume and priority:
  - Stimulus: HOLD at cnt=30, en reasserted with 5 pulses, en dropped, then datasyn edge.
  - Response: a2d_afc_ncntr=35.
  - Follow-up: datasyn edge issued while afc_cntr_rstn is low.
  - Response: no latch and no ncntr_valid pulse.
